// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU sequencer slice.
// Build option SEQ_ALIGN_TRAP_EN adds a FAULT state for misaligned word data accesses.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
`ifdef SEQ_ALIGN_TRAP_EN
    , FAULT = 3'd5
`endif
  } seq_state_t;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  typedef struct packed {
    logic rd_b;
    logic rd_w;
    logic wr_b;
    logic wr_w;
    logic pc_dest;
  } decoder_signals;

  function automatic logic is_mem_access(input decoder_signals d);
    return d.rd_b | d.rd_w | d.wr_b | d.wr_w;
  endfunction

  function automatic logic is_read_access(input decoder_signals d);
    return d.rd_b | d.rd_w;
  endfunction

  // Several strobes at once resolve as read over write, then word over byte.
  function automatic logic is_word_access(input decoder_signals d);
    return (d.rd_b | d.rd_w) ? d.rd_w : d.wr_w;
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_lane.sv
// Byte-lane steering for data accesses: store byte enables/replication and
// load byte selection/replication.
module mem_lane
  import cpu_pkg::*;
(
  input  logic        i_word,
  input  logic        i_addr_lsb,
  input  logic [15:0] i_rdata,
  input  logic [15:0] i_wr_val,
  output logic [1:0]  o_wr_be,
  output logic [15:0] o_wdata,
  output logic [15:0] o_ld_val
);

  logic [7:0] w_rd_byte;

  always_comb begin
    w_rd_byte = i_addr_lsb ? i_rdata[15:8] : i_rdata[7:0];
    if (i_word) begin
      o_wr_be  = BE_WORD;
      o_wdata  = i_wr_val;
      o_ld_val = i_rdata;
    end else begin
      o_wr_be  = i_addr_lsb ? BE_HI : BE_LO;
      o_wdata  = {2{i_wr_val[7:0]}};
      o_ld_val = {2{w_rd_byte}};
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch, execute, optional data access, writeback.
// Define SEQ_ALIGN_TRAP_EN to trap misaligned word data accesses into a sticky FAULT state.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        dec_rd_b,
  input  logic        dec_rd_w,
  input  logic        dec_wr_b,
  input  logic        dec_wr_w,
  input  logic        dec_pc_dest,
  input  logic [15:0] alu_result,
  input  logic [15:0] addr_val,
  input  logic [15:0] wr_val,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [15:0] ld_data,
  output logic        wb_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        fault
);

  seq_state_t     r_state;
  seq_state_t     w_next_state;
  logic [15:0]    r_pc;
  logic [15:0]    r_ir;
  logic [15:0]    r_ld_data;
  decoder_signals w_dec;
  logic           w_mem_op;
  logic           w_read;
  logic           w_word;
  logic [1:0]     w_lane_be;
  logic [15:0]    w_lane_wdata;
  logic [15:0]    w_lane_ld;

  always_comb begin
    w_dec.rd_b    = dec_rd_b;
    w_dec.rd_w    = dec_rd_w;
    w_dec.wr_b    = dec_wr_b;
    w_dec.wr_w    = dec_wr_w;
    w_dec.pc_dest = dec_pc_dest;
  end

  assign w_mem_op = is_mem_access(w_dec);
  assign w_read   = is_read_access(w_dec);
  assign w_word   = is_word_access(w_dec);

  mem_lane u_mem_lane (
    .i_word     (w_word),
    .i_addr_lsb (addr_val[0]),
    .i_rdata    (mem_rdata),
    .i_wr_val   (wr_val),
    .o_wr_be    (w_lane_be),
    .o_wdata    (w_lane_wdata),
    .o_ld_val   (w_lane_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (run) w_next_state = FETCH;
      FETCH: if (mem_ack) w_next_state = EXEC;
      EXEC: begin
        w_next_state = w_mem_op ? MEM : WB;
`ifdef SEQ_ALIGN_TRAP_EN
        if (w_mem_op && w_word && addr_val[0]) w_next_state = FAULT;
`endif
      end
      MEM:   if (mem_ack) w_next_state = WB;
      WB:    w_next_state = run ? FETCH : IDLE;
`ifdef SEQ_ALIGN_TRAP_EN
      FAULT: w_next_state = FAULT;
`endif
      default: w_next_state = IDLE;
    endcase
  end

  // Memory outputs depend only on state and held decoder inputs, so they stay
  // stable across wait cycles and drop as soon as the state leaves FETCH/MEM.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = BE_NONE;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    wb_en     = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_be   = BE_WORD;
        mem_addr = {r_pc[15:1], 1'b0};
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = ~w_read;
        mem_be    = w_read ? BE_WORD : w_lane_be;
        mem_addr  = w_word ? {addr_val[15:1], 1'b0} : addr_val;
        mem_wdata = w_read ? 16'h0000 : w_lane_wdata;
      end
      WB:      wb_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= NOP_INSTR;
      r_ld_data <= 16'h0000;
    end else begin
      if (r_state == FETCH && mem_ack)          r_ir      <= mem_rdata;
      if (r_state == MEM && mem_ack && w_read)  r_ld_data <= w_lane_ld;
      if (r_state == WB)                        r_pc      <= dec_pc_dest ? alu_result : r_pc + 16'd2;
    end
  end

  assign ir      = r_ir;
  assign pc      = r_pc;
  assign ld_data = r_ld_data;

`ifdef SEQ_ALIGN_TRAP_EN
  assign fault = (r_state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: inputs change and outputs are checked
// on the falling clock edge; expected values are hand-computed constants.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        dec_rd_b, dec_rd_w, dec_wr_b, dec_wr_w, dec_pc_dest;
  logic [15:0] alu_result, addr_val, wr_val;
  logic [15:0] ir, pc, ld_data;
  logic        wb_en;
  logic        mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        fault;

  int checkCount = 0;
  int errorCount = 0;

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .dec_rd_b    (dec_rd_b),
    .dec_rd_w    (dec_rd_w),
    .dec_wr_b    (dec_wr_b),
    .dec_wr_w    (dec_wr_w),
    .dec_pc_dest (dec_pc_dest),
    .alu_result  (alu_result),
    .addr_val    (addr_val),
    .wr_val      (wr_val),
    .ir          (ir),
    .pc          (pc),
    .ld_data     (ld_data),
    .wb_en       (wb_en),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the memory response for the next rising edge, then move to the following falling edge.
  task automatic applyStimulus(input logic ackVal, input logic [15:0] rdataVal);
    mem_ack   = ackVal;
    mem_rdata = rdataVal;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0;
    dec_rd_b = 1'b0; dec_rd_w = 1'b0; dec_wr_b = 1'b0; dec_wr_w = 1'b0; dec_pc_dest = 1'b0;
    alu_result = 16'h0000; addr_val = 16'h0000; wr_val = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_ir", ir, 16'hF000);
    checkOutput("rst_ld_data", ld_data, 16'h0000);
    checkOutput("rst_wb_en", {15'h0, wb_en}, 16'h0000);
    checkOutput("rst_mem_req", {15'h0, mem_req}, 16'h0000);
    checkOutput("rst_mem_be", {14'h0, mem_be}, 16'h0000);
    checkOutput("rst_fault", {15'h0, fault}, 16'h0000);

    $display("[TB] add instruction with zero-wait fetch");
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    applyStimulus(1'b1, 16'h0123);
    checkOutput("fetch_req", {15'h0, mem_req}, 16'h0001);
    checkOutput("fetch_we", {15'h0, mem_we}, 16'h0000);
    checkOutput("fetch_be", {14'h0, mem_be}, 16'h0003);
    checkOutput("fetch_addr", mem_addr, 16'h0000);
    applyStimulus(1'b1, 16'h0123);
    checkOutput("exec_ir", ir, 16'h0123);
    checkOutput("exec_req_drop", {15'h0, mem_req}, 16'h0000);
    checkOutput("exec_wb_en", {15'h0, wb_en}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("add_wb_en", {15'h0, wb_en}, 16'h0001);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("add_wb_done", {15'h0, wb_en}, 16'h0000);
    checkOutput("add_pc", pc, 16'h0002);
    checkOutput("fetch2_addr", mem_addr, 16'h0002);

    $display("[TB] byte load from odd address after a waited fetch");
    run = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    checkOutput("fetch_wait_req", {15'h0, mem_req}, 16'h0001);
    checkOutput("fetch_wait_addr", mem_addr, 16'h0002);
    dec_rd_b = 1'b1; addr_val = 16'h0011;
    applyStimulus(1'b1, 16'hF000);
    checkOutput("ldb_exec_req", {15'h0, mem_req}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("ldb_req", {15'h0, mem_req}, 16'h0001);
    checkOutput("ldb_we", {15'h0, mem_we}, 16'h0000);
    checkOutput("ldb_be", {14'h0, mem_be}, 16'h0003);
    checkOutput("ldb_addr", mem_addr, 16'h0011);
    applyStimulus(1'b1, 16'hAB34);
    checkOutput("ldb_data", ld_data, 16'hABAB);
    checkOutput("ldb_wb_en", {15'h0, wb_en}, 16'h0001);
    checkOutput("ldb_req_drop", {15'h0, mem_req}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("ldb_idle_wb", {15'h0, wb_en}, 16'h0000);
    checkOutput("ldb_pc", pc, 16'h0004);
    checkOutput("idle_req", {15'h0, mem_req}, 16'h0000);

    $display("[TB] byte store with ack delayed three cycles");
    dec_rd_b = 1'b0; dec_wr_b = 1'b1; addr_val = 16'h0020; wr_val = 16'h12C7; run = 1'b1;
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF000);
    run = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stb_req", {15'h0, mem_req}, 16'h0001);
      checkOutput("stb_we", {15'h0, mem_we}, 16'h0001);
      checkOutput("stb_be", {14'h0, mem_be}, 16'h0001);
      checkOutput("stb_wdata", mem_wdata, 16'hC7C7);
      checkOutput("stb_addr", mem_addr, 16'h0020);
      checkOutput("stb_no_wb", {15'h0, wb_en}, 16'h0000);
      applyStimulus(i == 3, 16'h0000);
    end
    mem_ack = 1'b0;
    checkOutput("stb_wb_en", {15'h0, wb_en}, 16'h0001);
    checkOutput("stb_req_drop", {15'h0, mem_req}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("stb_pc", pc, 16'h0006);

    $display("[TB] branch and pc wrap");
    dec_wr_b = 1'b0; dec_pc_dest = 1'b1; alu_result = 16'h0040; run = 1'b1;
    applyStimulus(1'b0, 16'h0000);
    checkOutput("br_fetch_addr", mem_addr, 16'h0006);
    applyStimulus(1'b1, 16'hF000);
    checkOutput("br_exec_req", {15'h0, mem_req}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("br_wb_en", {15'h0, wb_en}, 16'h0001);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("br_pc", pc, 16'h0040);
    checkOutput("br_fetch2_addr", mem_addr, 16'h0040);
    alu_result = 16'hFFFE;
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("br_pc_fffe", pc, 16'hFFFE);
    checkOutput("fetch_addr_fffe", mem_addr, 16'hFFFE);
    dec_pc_dest = 1'b0;
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("wrap_wb_en", {15'h0, wb_en}, 16'h0001);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("wrap_pc", pc, 16'h0000);

    $display("[TB] word store with byte strobe also set");
    dec_wr_w = 1'b1; dec_wr_b = 1'b1; addr_val = 16'h0044; wr_val = 16'hBEEF;
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("stw_we", {15'h0, mem_we}, 16'h0001);
    checkOutput("stw_be", {14'h0, mem_be}, 16'h0003);
    checkOutput("stw_wdata", mem_wdata, 16'hBEEF);
    checkOutput("stw_addr", mem_addr, 16'h0044);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("stw_pc", pc, 16'h0002);

    $display("[TB] misaligned word load with write strobe also set");
    dec_wr_w = 1'b0; dec_rd_w = 1'b1; addr_val = 16'h0031;
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b0, 16'h0000);
`ifdef SEQ_ALIGN_TRAP_EN
    checkOutput("trap_fault", {15'h0, fault}, 16'h0001);
    checkOutput("trap_no_req", {15'h0, mem_req}, 16'h0000);
    checkOutput("trap_no_wb", {15'h0, wb_en}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("trap_sticky", {15'h0, fault}, 16'h0001);
    checkOutput("trap_sticky_wb", {15'h0, wb_en}, 16'h0000);
    rst_n = 1'b0;
    #1;
    checkOutput("trap_reset_clear", {15'h0, fault}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000);
`else
    checkOutput("ldw_addr", mem_addr, 16'h0030);
    checkOutput("ldw_we", {15'h0, mem_we}, 16'h0000);
    checkOutput("ldw_fault", {15'h0, fault}, 16'h0000);
    applyStimulus(1'b1, 16'h5A3C);
    checkOutput("ldw_data", ld_data, 16'h5A3C);
    applyStimulus(1'b0, 16'h0000);
`endif

    $display("[TB] reset during a pending fetch");
    dec_rd_w = 1'b0; dec_wr_b = 1'b0;
    checkOutput("pend_req", {15'h0, mem_req}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", {15'h0, mem_req}, 16'h0000);
    checkOutput("midrst_pc", pc, 16'h0000);
    checkOutput("midrst_ir", ir, 16'hF000);
    checkOutput("midrst_ld_data", ld_data, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    applyStimulus(1'b1, 16'h1234);
    checkOutput("late_ack_req", {15'h0, mem_req}, 16'h0000);
    checkOutput("late_ack_ir", ir, 16'hF000);
    checkOutput("late_ack_wb", {15'h0, wb_en}, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("late_ack_pc", pc, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  in  1  1 = sequencer may start a new instruction.
REQ-005 SHALL have port dec_rd_b, dec_rd_w, dec_wr_b, dec_wr_w  in  1 each  decoder memory-access strobes for the held instruction.
REQ-006 SHALL have port dec_pc_dest  in  1  decoder aluDest (1 = result written to PC).
REQ-007 SHALL have port alu_result  in  16  ALU output, used as new PC when dec_pc_dest=1.
REQ-008 SHALL have port addr_val / wr_val  in  16 each  register-file values for data address and store data.
REQ-009 SHALL have port ir  out  16  instruction register driven to decoder.
REQ-010 SHALL have port pc  out  16  current program counter.
REQ-011 SHALL have port ld_data  out  16  latched load data.
REQ-012 SHALL have port wb_en  out  1  one-cycle register/flag commit strobe.
REQ-013 SHALL have port mem_req, mem_we  out  1 each; mem_be  out  2; mem_addr, mem_wdata  out  16; mem_ack  in  1; mem_rdata  in  16  memory port.
REQ-014 SHALL have port fault  out  1  sticky misaligned-access indicator.

Function
REQ-015 SHALL implement states IDLE, FETCH, EXEC, MEM, WB (FAULT only with macro).
REQ-016 IDLE -> FETCH when run=1; otherwise stay in IDLE.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_be=2'b11, mem_addr={pc[15:1],1'b0}; on mem_ack, ir<=mem_rdata, -> EXEC.
REQ-018 mem_req, mem_addr, mem_we, mem_be, mem_wdata SHALL stay stable until mem_ack is sampled 1; ack in the first request cycle is legal; mem_req SHALL be 0 the cycle after ack.
REQ-019 EXEC: one cycle; -> MEM if any dec_rd_*/dec_wr_* set, else -> WB.
REQ-020 MEM read: mem_addr=addr_val (word: bit0 forced 0); on ack, ld_data <= word ? mem_rdata : {B,B} where B = addr_val[0] ? mem_rdata[15:8] : mem_rdata[7:0].
REQ-021 MEM write: mem_we=1; word: mem_be=2'b11, mem_wdata=wr_val; byte: mem_be = addr_val[0] ? 2'b10 : 2'b01, mem_wdata={wr_val[7:0],wr_val[7:0]}.
REQ-022 WB: wb_en=1 for exactly one cycle; pc <= dec_pc_dest ? alu_result : pc+2 (16-bit wrap, 16'hFFFE+2=16'h0000); -> FETCH if run=1 else IDLE.
REQ-023 Latency: non-memory instruction = fetch ack cycle + 2; memory instruction = fetch ack + data ack + 2.
REQ-024 run=0 SHALL NOT abort an instruction already past IDLE.
REQ-025 Only one of dec_rd_*/dec_wr_* is valid; if several are set, read SHALL take priority over write, word over byte.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, pc=RESET_PC, ir=16'hF000 (nop), ld_data=0, wb_en=0, mem_req=0, mem_we=0, mem_be=0, fault=0.
REQ-027 Reset mid-handshake SHALL drop mem_req without waiting for mem_ack; a late ack after reset SHALL be ignored.

Configuration
REQ-028 Macro SEQ_ALIGN_TRAP_EN: defined -> word data access with addr_val[0]=1 in EXEC goes to FAULT, no mem_req, fault=1, no wb_en; FAULT exits only by reset.
REQ-029 Undefined -> no FAULT state, fault tied 0, misaligned word address silently forced to bit0=0.

Structure
REQ-030 State enum, nop encoding 16'hF000 and mem_be constants SHALL live in shared package cpu_pkg, alongside decoder_signals.
REQ-031 Byte-lane select/replicate logic SHALL be sub-module mem_lane (combinational), instantiated once.

Verification
REQ-032 Reset, run=1, memory returns 16'h0123 (add) at addr 0 with 0-wait ack -> wb_en pulses cycle 3, pc=16'h0002.
REQ-033 Byte load, addr_val=16'h0011, mem_rdata=16'hAB34 -> ld_data=16'hABAB, mem_be=2'b11 read, 1 wb_en.
REQ-034 Byte store, addr_val=16'h0020, wr_val=16'h12C7, ack delayed 3 cycles -> mem_be=2'b01, mem_wdata=16'hC7C7 held stable 4 cycles, no wb_en until after ack.
REQ-035 Branch with dec_pc_dest=1, alu_result=16'h0040 -> pc=16'h0040; pc=16'hFFFE non-branch -> pc=16'h0000.
REQ-036 Word load addr_val=16'h0031: with SEQ_ALIGN_TRAP_EN -> fault=1, no mem_req; without -> mem_addr=16'h0030.
REQ-037 rst_n low while mem_req=1 awaiting ack -> mem_req=0 same cycle, pc=RESET_PC, later ack ignored.
